// File: rtl/alu_writeback.sv
// alu_writeback: commit stage behind the 16-bit ALU of a Hack-style CPU.
// Updates A/D, issues data-memory writes with an ack handshake, evaluates
// jump conditions for the PC, and freezes on a jump-to-self (program end).
module alu_writeback #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    instr,
  input  logic [WIDTH-1:0]    alu_out,
  input  logic                zr,
  input  logic                ng,
  output logic [WIDTH-1:0]    a_reg,
  output logic [WIDTH-1:0]    d_reg,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                mem_we,
  input  logic                mem_ack,
  output logic                halted
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALTED   = 2'd2;

  logic [1:0]          state;
  logic                halt_pend;   // self-loop seen while a write is still outstanding
  logic                accept;
  logic                is_c;
  logic                pos;
  logic                take;
  logic                hit;
  logic [PC_WIDTH-1:0] a_lo;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                unused_bits;

  assign in_ready    = (state == RUN) && !reset;
  assign accept      = in_valid && in_ready;
  assign is_c        = instr[WIDTH-1];
  assign pos         = ~zr & ~ng;
  assign take        = (instr[2] & ng) | (instr[1] & zr) | (instr[0] & pos);
  assign a_lo        = a_reg[PC_WIDTH-1:0];
  assign pc_inc      = pc + PC_WIDTH'(1);
  // Jumping to the current PC can never leave it again: that is program end.
  assign hit         = take && (a_lo == pc);
  assign unused_bits = ^instr[WIDTH-2:6];

  // Architectural state, write handshake and run/wait/halt sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      d_reg     <= '0;
      pc        <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      halted    <= 1'b0;
      halt_pend <= 1'b0;
      state     <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            if (!is_c) begin
              a_reg <= instr;
              pc    <= pc_inc;
            end else begin
              // a_lo is sampled before this edge, so A-writes do not affect the target.
              if (instr[5]) a_reg <= alu_out;
              if (instr[4]) d_reg <= alu_out;
              pc <= take ? a_lo : pc_inc;
              if (instr[3]) begin
                mem_addr  <= a_lo;
                mem_wdata <= alu_out;
                mem_we    <= 1'b1;
                halt_pend <= hit;
                state     <= MEM_WAIT;
              end else if (hit) begin
                halted <= 1'b1;
                state  <= HALTED;
              end
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            mem_we    <= 1'b0;
            halt_pend <= 1'b0;
            if (halt_pend) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state <= RUN;
            end
          end
        end
        default: ;  // HALTED: frozen until reset
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed plan items with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_alu_writeback;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, zr, ng, mem_we, mem_ack, halted;
  logic [15:0] instr, alu_out, a_reg, d_reg, mem_wdata;
  logic [14:0] pc, mem_addr;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  logic [15:0] m_a, m_d, m_wd;
  logic [14:0] m_pc, m_ma;
  logic        m_we, m_halt, m_pend;
  int          m_mode;  // 0 run, 1 waiting for ack, 2 halted

  alu_writeback dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .alu_out(alu_out), .zr(zr), .ng(ng),
    .a_reg(a_reg), .d_reg(d_reg), .pc(pc), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the architectural rules, from the sampled inputs.
  task automatic model_edge();
    logic [14:0] aold;
    logic        tk, self;
    if (reset) begin
      m_a = 0; m_d = 0; m_pc = 0; m_ma = 0; m_wd = 0;
      m_we = 0; m_halt = 0; m_pend = 0; m_mode = 0;
    end else if (m_mode == 1) begin
      if (mem_ack) begin
        m_we = 0;
        m_mode = m_pend ? 2 : 0;
        if (m_pend) m_halt = 1;
        m_pend = 0;
      end
    end else if (m_mode == 0 && in_valid) begin
      if (!instr[15]) begin
        m_a  = instr;
        m_pc = m_pc + 15'd1;
      end else begin
        aold = m_a[14:0];
        tk   = (instr[2] && ng) || (instr[1] && zr) || (instr[0] && !zr && !ng);
        self = tk && (aold == m_pc);
        if (instr[5]) m_a = alu_out;
        if (instr[4]) m_d = alu_out;
        m_pc = tk ? aold : m_pc + 15'd1;
        if (instr[3]) begin
          m_ma = aold; m_wd = alu_out; m_we = 1; m_mode = 1; m_pend = self;
        end else if (self) begin
          m_mode = 2; m_halt = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("a_reg", 32'(a_reg), 32'(m_a));
    chk("d_reg", 32'(d_reg), 32'(m_d));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    if (m_we) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_ma));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
    end
    chk("halted", 32'(halted), 32'(m_halt));
    chk("in_ready", 32'(in_ready), 32'(m_mode == 0 && !reset));
  endtask

  // Drive one beat at the falling edge, let the DUT and model take the
  // rising edge, then compare at the next falling edge.
  task automatic cyc(input logic v, input logic [15:0] ins, input logic [15:0] alu,
                     input logic z, input logic n, input logic ack, input logic rst);
    in_valid = v; instr = ins; alu_out = alu; zr = z; ng = n; mem_ack = ack; reset = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    cyc(0, 16'h0, 16'h0, 0, 0, 0, 1);
    cyc(0, 16'h0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic ainst(input logic [15:0] v);
    cyc(1, v, 16'h0, 0, 0, 0, 0);
  endtask

  // a_reg=0x0040, pc=3
  task automatic setup_a40();
    do_reset();
    ainst(16'h0001); ainst(16'h0002); ainst(16'h0040);
  endtask

  initial begin
    @(negedge clk);
    // reset state
    do_reset();
    chk("rst_a", 32'(a_reg), 0); chk("rst_pc", 32'(pc), 0);
    chk("rst_we", 32'(mem_we), 0); chk("rst_halt", 32'(halted), 0);

    // A then C dest=D
    ainst(16'h0005);
    cyc(1, 16'hEC10, 16'h0005, 0, 0, 0, 0);
    chk("ad_a", 32'(a_reg), 32'h5); chk("ad_d", 32'(d_reg), 32'h5);
    chk("ad_pc", 32'(pc), 2); chk("ad_rdy", 32'(in_ready), 1);

    // memory write with 3 cycles of back-pressure
    ainst(16'h0010);
    cyc(1, 16'hE008, 16'h1234, 0, 0, 0, 0);
    chk("mw_we", 32'(mem_we), 1); chk("mw_addr", 32'(mem_addr), 32'h10);
    chk("mw_data", 32'(mem_wdata), 32'h1234); chk("mw_rdy", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'h0099, 16'h0, 0, 0, 0, 0);
      chk("mw_hold_data", 32'(mem_wdata), 32'h1234);
    end
    cyc(0, 16'h0, 16'h0, 0, 0, 1, 0);
    chk("mw_ack_we", 32'(mem_we), 0); chk("mw_ack_rdy", 32'(in_ready), 1);
    chk("mw_pc", 32'(pc), 4); chk("mw_a_kept", 32'(a_reg), 32'h10);

    // jump matrix
    setup_a40(); cyc(1, 16'hE004, 16'h0, 0, 1, 0, 0); chk("jlt", 32'(pc), 32'h40);
    setup_a40(); cyc(1, 16'hE002, 16'h0, 0, 0, 0, 0); chk("jeq", 32'(pc), 32'h4);
    setup_a40(); cyc(1, 16'hE001, 16'h0, 0, 0, 0, 0); chk("jgt", 32'(pc), 32'h40);
    setup_a40(); cyc(1, 16'hE007, 16'h0, 0, 1, 0, 0); chk("jmp", 32'(pc), 32'h40);

    // target uses A before the same instruction rewrites it
    do_reset(); ainst(16'h0020);
    cyc(1, 16'hE027, 16'h0077, 0, 0, 0, 0);
    chk("aold_pc", 32'(pc), 32'h20); chk("aold_a", 32'(a_reg), 32'h77);

    // pc wrap
    do_reset(); ainst(16'h7FFF);
    cyc(1, 16'hE007, 16'h0, 1, 0, 0, 0);
    chk("wrap_pre", 32'(pc), 32'h7FFF);
    ainst(16'h0009);
    chk("wrap", 32'(pc), 0);

    // self-loop halt: pc=9, a=9
    cyc(1, 16'hE007, 16'h0, 1, 0, 0, 0);
    chk("halt_pre", 32'(pc), 9);
    cyc(1, 16'hE007, 16'h0, 1, 0, 0, 0);
    chk("halt", 32'(halted), 1); chk("halt_rdy", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) cyc(1, 16'h0123, 16'h0, 0, 0, 1, 0);
    chk("halt_frozen_a", 32'(a_reg), 9); chk("halt_stay", 32'(halted), 1);
    do_reset();
    chk("unhalt", 32'(halted), 0); chk("unhalt_pc", 32'(pc), 0);

    // self-loop combined with an M write: halt deferred until ack
    ainst(16'h0001);
    cyc(1, 16'hE00F, 16'h0055, 1, 0, 0, 0);
    chk("hm_we", 32'(mem_we), 1); chk("hm_nohalt", 32'(halted), 0);
    chk("hm_addr", 32'(mem_addr), 1);
    cyc(0, 16'h0, 16'h0, 0, 0, 1, 0);
    chk("hm_halt", 32'(halted), 1); chk("hm_we_off", 32'(mem_we), 0);
    chk("hm_rdy", 32'(in_ready), 0);

    // reset in the middle of a write wait
    do_reset(); ainst(16'h0010);
    cyc(1, 16'hE018, 16'h4444, 0, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0, 1);
    chk("rw_we", 32'(mem_we), 0); chk("rw_d", 32'(d_reg), 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 1, 0);
    chk("rw_late_ack_we", 32'(mem_we), 0); chk("rw_rdy", 32'(in_ready), 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ins;
      logic        z, n;
      ins = 16'($urandom);
      if ($urandom_range(0, 1) == 0) ins[15] = 1'b0;
      else ins[15:13] = 3'b111;
      z = ($urandom_range(0, 3) == 0);
      n = z ? 1'b0 : 1'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), ins, 16'($urandom), z, n,
          1'($urandom_range(0, 2) == 0), $urandom_range(0, 59) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream stage of the 16-bit ALU in the CPU datapath.
- Consumes the ALU result together with the `zr`/`ng` flags and the current Hack-format instruction.
- Commits results into the A and D registers, issues data-memory writes (M), and evaluates jump conditions to update the program counter.
- Provides a valid/ready handshake toward the execute stage, stalls on memory writes, and detects the program-terminating self-loop.

Parameters:
- WIDTH, 16, data width of the instruction, ALU result, and A/D registers.
- PC_WIDTH, 15, program counter width; the PC wraps modulo 2^PC_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  execute stage presents instr/alu_out/zr/ng.
- in_ready  output  1  stage can accept a beat this cycle.
- instr  input  WIDTH  current instruction (bit15=0 A-instr; 1 C-instr: [5:3] dest A,D,M; [2:0] jump j1,j2,j3).
- alu_out  input  WIDTH  ALU result.
- zr  input  1  ALU zero flag.
- ng  input  1  ALU negative flag.
- a_reg  output  WIDTH  A register.
- d_reg  output  WIDTH  D register.
- pc  output  PC_WIDTH  program counter.
- mem_addr  output  PC_WIDTH  data-memory write address.
- mem_wdata  output  WIDTH  data-memory write data.
- mem_we  output  1  write request, held until acknowledged.
- mem_ack  input  1  memory accepted the write.
- halted  output  1  self-loop detected; stage frozen.

Behaviour:
- Clock and reset:
  - Single clock domain `clk`.
  - `reset` is synchronous and active-high.
  - Reset values: a_reg=0, d_reg=0, pc=0, mem_addr=0, mem_wdata=0, mem_we=0, halted=0, state=RUN.
  - Reset has priority over every other event, including mid-MEM_WAIT; any pending write is abandoned.
- States:
  - RUN: accepting.
  - MEM_WAIT: write outstanding.
  - HALTED: frozen.
  - in_ready = (state==RUN) and not reset.
- Acceptance:
  - A beat is accepted when in_valid & in_ready.
  - All register updates take effect at that clock edge; latency is 1 cycle.
  - No update occurs without acceptance.
- A-instruction (instr[15]=0):
  - a_reg <= instr.
  - pc <= pc+1.
  - D and memory are untouched.
- C-instruction, destinations (A_old = a_reg before the edge):
  - instr[5]: a_reg <= alu_out.
  - instr[4]: d_reg <= alu_out.
  - instr[3]: mem_addr <= A_old[PC_WIDTH-1:0], mem_wdata <= alu_out, mem_we <= 1, state <= MEM_WAIT.
- C-instruction, jump evaluation:
  - pos = ~zr & ~ng.
  - take = (instr[2]&ng) | (instr[1]&zr) | (instr[0]&pos).
  - pc <= take ? A_old[PC_WIDTH-1:0] : pc+1.
  - The jump target uses A_old even if the same instruction writes A.
- Halt detection:
  - Condition: accepted C-instruction with take=1 and A_old[PC_WIDTH-1:0]==pc.
  - Result: state <= HALTED, halted <= 1.
  - If M is also written: mem_we still asserts, state goes to MEM_WAIT, and the HALTED transition occurs on mem_ack.
  - HALTED persists until reset.
- MEM_WAIT:
  - mem_we, mem_addr, and mem_wdata are held stable.
  - in_ready=0.
  - On mem_ack: mem_we <= 0, state <= RUN (or HALTED if pending).
  - mem_ack outside MEM_WAIT is ignored.
- PC arithmetic:
  - pc+1 wraps 2^PC_WIDTH-1 -> 0.
  - alu_out and A are WIDTH bits with no saturation.
- Output timing: outputs are registered; a_reg/d_reg/pc reflect committed state only.

Test Plan:
- Reset, then A-instr 0x0005, then C-instr dest=D (instr=0xEC10 style, alu_out=0x0005) -> a_reg=0x0005, d_reg=0x0005, pc=2; in_ready high throughout.
- a_reg=0x0010, C-instr dest=M, alu_out=0x1234 -> next cycle mem_we=1, mem_addr=0x0010, mem_wdata=0x1234, in_ready=0; hold mem_ack low 3 cycles -> outputs stable; mem_ack=1 -> mem_we=0 and in_ready=1 next cycle.
- Jump matrix, a_reg=0x0040, pc=0x0003: JLT with ng=1 -> pc=0x0040; JEQ with zr=0 -> pc=0x0004; JGT with zr=0/ng=0 -> pc=0x0040; JMP (all bits) -> pc=0x0040.
- Same instruction writes A=0x0077 and JMP with A_old=0x0020 -> pc=0x0020, a_reg=0x0077.
- pc=0x7FFF, A-instr accepted -> pc=0x0000. Separately, pc=0x0009, a_reg=0x0009, JMP -> halted=1, in_ready=0 indefinitely; reset -> all zeros, halted=0.
- Reset asserted during MEM_WAIT -> next cycle mem_we=0, state RUN, all registers 0; a late mem_ack is ignored.
